// File: rtl/dpram_fifo_ctrl_if.sv
// Bundle of the producer stream, consumer stream, status flags and RAM port signals
// for dpram_fifo_ctrl. The controller uses the master modport; the environment uses slave.
interface dpram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  // Handshake: a word moves on a rising clk edge exactly when valid && ready are both 1.
  // The sender holds valid and data stable until that happens; ready may change freely.
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] ram_data_a;
  logic [ADDR_WIDTH-1:0] ram_addr_a;
  logic                  ram_we_a;
  logic [DATA_WIDTH-1:0] ram_data_b;
  logic [ADDR_WIDTH-1:0] ram_addr_b;
  logic                  ram_we_b;
  logic [DATA_WIDTH-1:0] ram_q_b;

  modport master (
    input  s_data, s_valid, m_ready, ram_q_b,
    output s_ready, m_data, m_valid, count, full, empty,
           ram_data_a, ram_addr_a, ram_we_a, ram_data_b, ram_addr_b, ram_we_b
  );

  modport slave (
    output s_data, s_valid, m_ready, ram_q_b,
    input  s_ready, m_data, m_valid, count, full, empty,
           ram_data_a, ram_addr_a, ram_we_a, ram_data_b, ram_addr_b, ram_we_b
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM with registered reads: port A writes,
// port B prefetches into a 2-entry output buffer for a first-word-fall-through stream.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  dpram_fifo_ctrl_if.master bus
);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_occ;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] ob_q [2];
  logic [DATA_WIDTH-1:0] ob_d [2];
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [1:0]            ob_keep;
  logic [2:0]            pending;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  fetch;

  // Occupancy peaks at exactly 2^ADDR_WIDTH, so the top bit alone marks full.
  assign ram_occ = wr_ptr_q - rd_ptr_q;
  assign full    = ram_occ[ADDR_WIDTH];
  assign push    = bus.s_valid && !full;
  assign pop     = (ob_cnt_q != 2'd0) && bus.m_ready;

  // Words that will sit in or head for the buffer after this cycle's pop; a fetch
  // is only issued when a slot is guaranteed for its data next cycle.
  assign pending = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fetch   = (ram_occ != '0) && (pending < 3'd2);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, fetch};
    inflight_d = fetch;
    ob_d       = ob_q;
    ob_keep    = ob_cnt_q - {1'b0, pop};
    if (pop) begin
      ob_d[0] = ob_q[1];
    end
    // The returning word lands right behind whatever survives the pop.
    if (inflight_q) begin
      ob_d[ob_keep[0]] = bus.ram_q_b;
    end
    ob_cnt_d = ob_keep + {1'b0, inflight_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      ob_q[0]    <= '0;
      ob_q[1]    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob_q[0]    <= ob_d[0];
      ob_q[1]    <= ob_d[1];
    end
  end

  assign bus.s_ready    = !full;
  assign bus.full       = full;
  assign bus.m_data     = ob_q[0];
  assign bus.m_valid    = (ob_cnt_q != 2'd0);
  assign bus.count      = ram_occ + {{ADDR_WIDTH{1'b0}}, inflight_q}
                        + {{(ADDR_WIDTH-1){1'b0}}, ob_cnt_q};
  assign bus.empty      = (bus.count == '0);
  assign bus.ram_we_a   = push && !rst;
  assign bus.ram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.ram_data_a = bus.s_data;
  assign bus.ram_data_b = '0;
  assign bus.ram_addr_b = rd_ptr_q[ADDR_WIDTH-1:0];
  assign bus.ram_we_b   = 1'b0;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural registered-read dual-port RAM,
// a directed vector table, and hand sequences for fill, wrap, random flow and reset.
module tb_dpram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dpram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.ram_q_b = '0;
  end

  // A same-address read during a write returns a poison value, so any reliance
  // on read-during-write behaviour shows up as corrupted data.
  always @(posedge clk) begin
    if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_data_a;
    if (bus.ram_we_a && bus.ram_addr_a == bus.ram_addr_b) bus.ram_q_b <= 8'hEE;
    else bus.ram_q_b <= mem[bus.ram_addr_b];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic mon_en = 1'b0;
  int pushed = 0;
  int popped = 0;
  int wraps = 0;
  int max_count = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("count_vs_model", 32'(bus.count), 32'(exp_q.size()));
      chk("ram_we_b_zero", 32'(bus.ram_we_b), 32'd0);
      if (32'(bus.count) > max_count) max_count = 32'(bus.count);
      if (bus.ram_we_a) begin
        if (last_addr == 6'd63 && bus.ram_addr_a == 6'd0) wraps++;
        last_addr = bus.ram_addr_a;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("pop_with_model_empty", 32'(bus.m_valid), 32'd0);
        else begin
          chk("data_order", 32'(bus.m_data), 32'(exp_q.pop_front()));
          popped++;
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(bus.s_data);
        pushed++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"},  32'(bus.m_valid),  32'd0);
    chk({tag, "_m_data"},   32'(bus.m_data),   32'd0);
    chk({tag, "_count"},    32'(bus.count),    32'd0);
    chk({tag, "_empty"},    32'(bus.empty),    32'd1);
    chk({tag, "_full"},     32'(bus.full),     32'd0);
    chk({tag, "_s_ready"},  32'(bus.s_ready),  32'd1);
    chk({tag, "_ram_we_a"}, 32'(bus.ram_we_a), 32'd0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    bus.s_valid = 1'b1;  // pushing during reset must not write the RAM
    bus.s_data  = 8'hA5;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    exp_q.delete();
    pushed = 0; popped = 0; wraps = 0; max_count = 0; last_addr = '0;
    next_cycle();
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while (n < budget && !(bus.empty && exp_q.size() == 0)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          we;
    logic [AW-1:0] addr_a;
    logic          mv;
    logic [DW-1:0] md;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single word then a second word, traced from reset cycle by cycle
    vecs[0] = '{sv:1'b1, sd:8'h33, mr:1'b0, we:1'b1, addr_a:6'd0, mv:1'b0, md:8'h00, cnt:7'd0};
    vecs[1] = '{sv:1'b1, sd:8'h44, mr:1'b0, we:1'b1, addr_a:6'd1, mv:1'b0, md:8'h00, cnt:7'd1};
    vecs[2] = '{sv:1'b0, sd:8'h00, mr:1'b1, we:1'b0, addr_a:6'd0, mv:1'b0, md:8'h00, cnt:7'd2};
    vecs[3] = '{sv:1'b0, sd:8'h00, mr:1'b1, we:1'b0, addr_a:6'd0, mv:1'b1, md:8'h33, cnt:7'd2};
    vecs[4] = '{sv:1'b0, sd:8'h00, mr:1'b0, we:1'b0, addr_a:6'd0, mv:1'b1, md:8'h44, cnt:7'd1};
    vecs[5] = '{sv:1'b0, sd:8'h00, mr:1'b1, we:1'b0, addr_a:6'd0, mv:1'b1, md:8'h44, cnt:7'd1};
    vecs[6] = '{sv:1'b0, sd:8'h00, mr:1'b0, we:1'b0, addr_a:6'd0, mv:1'b0, md:8'h00, cnt:7'd0};

    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.m_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      bus.s_valid = vecs[i].sv;
      bus.s_data  = vecs[i].sd;
      bus.m_ready = vecs[i].mr;
      @(negedge clk);
      chk("vec_we_a", 32'(bus.ram_we_a), 32'(vecs[i].we));
      if (vecs[i].we) chk("vec_addr_a", 32'(bus.ram_addr_a), 32'(vecs[i].addr_a));
      chk("vec_m_valid", 32'(bus.m_valid), 32'(vecs[i].mv));
      if (vecs[i].mv) chk("vec_m_data", 32'(bus.m_data), 32'(vecs[i].md));
      chk("vec_count", 32'(bus.count), 32'(vecs[i].cnt));
      chk("vec_empty", 32'(bus.empty), 32'(vecs[i].cnt == 7'd0));
      chk("vec_s_ready", 32'(bus.s_ready), 32'd1);
      next_cycle();
    end

    // fill to 66 words with the consumer stalled, then drain
    do_reset();
    for (int i = 0; i < 66; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(i);
      @(negedge clk);
      if (!bus.s_ready) chk("fill_s_ready", 32'(bus.s_ready), 32'd1);
      next_cycle();
    end
    bus.s_data = 8'h42;
    @(negedge clk);
    chk("full_flag", 32'(bus.full), 32'd1);
    chk("full_s_ready", 32'(bus.s_ready), 32'd0);
    chk("full_count", 32'(bus.count), 32'd66);
    chk("full_no_write", 32'(bus.ram_we_a), 32'd0);
    next_cycle();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("full_count_hold", 32'(bus.count), 32'd66);
    next_cycle();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      if (!bus.m_valid || bus.m_data != 8'(i)) begin
        chk("drain_m_valid", 32'(bus.m_valid), 32'd1);
        chk("drain_m_data", 32'(bus.m_data), 32'(i));
      end else checks++;
      next_cycle();
    end
    @(negedge clk);
    chk("drain_empty_after", 32'(bus.empty), 32'd1);
    chk("drain_m_valid_after", 32'(bus.m_valid), 32'd0);
    next_cycle();
    bus.m_ready = 1'b0;

    // wrap-around streaming with the consumer always ready
    do_reset();
    mon_en = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(i);
      next_cycle();
    end
    bus.s_valid = 1'b0;
    wait_drained(20);
    chk("stream_popped", 32'(popped), 32'd200);
    chk("stream_wraps", 32'(wraps), 32'd3);
    chk("stream_count_max_le3", 32'(max_count <= 3), 32'd1);
    mon_en = 1'b0;

    // random back-pressure on both sides
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!(bus.s_valid && !bus.s_ready)) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data  = 8'($urandom_range(0, 255));
      end
      bus.m_ready = 1'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 1));
      next_cycle();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    wait_drained(200);
    chk("random_balance", 32'(popped), 32'(pushed));
    mon_en = 1'b0;

    // reset with 20 words held and a read in flight
    do_reset();
    for (int i = 0; i < 21; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(8'hA0 + i);
      next_cycle();
    end
    bus.s_valid = 1'b0;
    next_cycle();
    next_cycle();
    bus.m_ready = 1'b1;
    next_cycle();
    bus.m_ready = 1'b0;
    chk("pre_rst_count", 32'(bus.count), 32'd20);
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h99;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    next_cycle();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    @(negedge clk);
    chk("post_rst_we_a", 32'(bus.ram_we_a), 32'd1);
    chk("post_rst_addr_a", 32'(bus.ram_addr_a), 32'd0);
    next_cycle();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int n = 0; n < 10 && !bus.m_valid; n++) next_cycle();
    @(negedge clk);
    chk("post_rst_m_valid", 32'(bus.m_valid), 32'd1);
    chk("post_rst_m_data", 32'(bus.m_data), 32'h55);
    next_cycle();
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_empty", 32'(bus.empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller built around the existing `dual_port_ram` (8-bit data, 6-bit address, registered read). It sits upstream of the RAM and drives its ports. Port A is write-only and fed by a valid/ready producer. Port B is read-only and prefetches into a 2-entry output buffer, giving consumers a first-word-fall-through valid/ready stream at one word per cycle.

## Interface
- `DATA_WIDTH`, 8, word width; must match the RAM data width.
- `ADDR_WIDTH`, 6, RAM address width; RAM depth = 2^ADDR_WIDTH = 64.
- `clk`  in  1  single clock for the controller and the attached RAM.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_data`  in  DATA_WIDTH  write data.
- `s_valid`  in  1  producer has data.
- `s_ready`  out  1  controller accepts data (= !full).
- `m_data`  out  DATA_WIDTH  head-of-FIFO word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer takes the word.
- `count`  out  ADDR_WIDTH+1  total words held (RAM + in-flight + output buffer), max 2^ADDR_WIDTH+2.
- `full`  out  1  RAM occupancy == 2^ADDR_WIDTH.
- `empty`  out  1  `count` == 0.
- `ram_data_a`  out  DATA_WIDTH  RAM port-A write data.
- `ram_addr_a`  out  ADDR_WIDTH  RAM port-A address.
- `ram_we_a`  out  1  RAM port-A write enable.
- `ram_data_b`  out  DATA_WIDTH  tied 0.
- `ram_addr_b`  out  ADDR_WIDTH  RAM port-B read address.
- `ram_we_b`  out  1  tied 0.
- `ram_q_b`  in  DATA_WIDTH  RAM port-B registered read data.

## Operation
- **State:**
  - `wr_ptr`, `rd_ptr`: ADDR_WIDTH+1 bits each; the MSB is the wrap bit.
  - `ram_occ` = `wr_ptr` − `rd_ptr` (modulo 2^(ADDR_WIDTH+1)).
  - `inflight`: 1 bit.
  - Output buffer `ob[0..1]` with `ob_cnt` (0..2).
- **Push:**
  - A push occurs when `s_valid && s_ready`.
  - Combinationally drive `ram_we_a`=1, `ram_addr_a`=`wr_ptr[ADDR_WIDTH-1:0]`, `ram_data_a`=`s_data`.
  - `wr_ptr`++ at the edge.
  - `ram_we_a`=0 whenever there is no push or `rst`=1.
- **Fetch:**
  - A fetch is issued when `ram_occ`>0 and (`ob_cnt` + `inflight` − pop) < 2, where pop = `m_valid && m_ready`.
  - Drive `ram_addr_b`=`rd_ptr[ADDR_WIDTH-1:0]`; `rd_ptr`++ at the edge; `inflight` <= fetch.
- **Capture:** in any cycle with `inflight`=1, `ram_q_b` is appended to the output buffer at the edge, behind any word not being popped.
- **Pop:**
  - `m_data`=`ob[0]`, `m_valid`=(`ob_cnt`>0).
  - On pop, `ob[1]` shifts to `ob[0]`.
  - Capture and pop in the same cycle are allowed; `ob_cnt` changes by (capture − pop).
- **No address collision:** fetch requires `ram_occ`>0 and push requires `ram_occ`<depth, so `ram_addr_a` ≠ `ram_addr_b` whenever both ports are active. The controller never relies on RAM read-during-write behaviour.
- **Flags:**
  - `full` depends on RAM occupancy only, so total capacity = 2^ADDR_WIDTH + 2 = 66 words.
  - `s_ready`=!`full`, computed combinationally from registered state only (no dependence on `m_ready`).
- **Pointer wrap:** pointers wrap naturally at 2^(ADDR_WIDTH+1). Address bits wrap 63→0.
- **Ordering:** strict FIFO; no word is lost or duplicated under any valid/ready pattern.
- **Reset:**
  - Asynchronous; state values:
    - pointers = 0
    - `inflight` = 0
    - `ob_cnt` = 0
    - `ob` contents = 0
  - Resulting outputs:
    - `m_valid` = 0
    - `m_data` = 0
    - `count` = 0
    - `empty` = 1
    - `full` = 0
    - `s_ready` = 1
    - `ram_we_a` = 0
  - Reset mid-operation discards all contents, including an in-flight read. The first push after release lands at RAM address 0.

## Timing
- The RAM samples addresses and data on rising `clk`; `ram_q_b` is valid the cycle after `ram_addr_b` is sampled.
- **Latency, empty FIFO:**
  - Push accepted at edge E0 → fetch driven in cycle E0–E1.
  - `ram_q_b` valid after E1 → captured at E2.
  - `m_valid`=1 after E2.
- **Throughput:** sustained 1 push + 1 pop per cycle once primed (steady state `ob_cnt`=1, `inflight`=1).
- **`count` update:** updates at the edge by (push − pop).
- **Simultaneous push and pop:** `count` unchanged.
- **Full boundary:**
  - Push at `ram_occ`=63 with a same-cycle fetch leaves `ram_occ`=63 and `full` stays 0.
  - Without a fetch, `full`=1 after that edge.
  - `s_ready` drops in the same cycle `full` rises.

## Test plan
- **Reset values:** assert `rst` mid-cycle → immediately `m_valid`=0, `count`=0, `empty`=1, `s_ready`=1, `ram_we_a`=0.
- **Single word:** push 0x33 at E0 → `ram_addr_a`=0, `ram_we_a`=1 in that cycle; `m_valid`=1, `m_data`=0x33 after E2; pop → `empty`=1.
- **Fill and drain:**
  - With `m_ready`=0, push 0x00..0x41 (66 words) → `full`=1, `s_ready`=0, `count`=66.
  - The 67th push is not accepted.
  - Drain with `m_ready`=1 → words come out 0x00..0x41 in order at 1/cycle.
- **Wrap-around streaming:**
  - 200 pushes of an incrementing byte, with `m_ready` held high → output sequence identical.
  - `ram_addr_a` wraps 63→0 three times.
  - `count` stays ≤ 3.
- **Back-pressure:** random `s_valid`/`m_ready` over 1000 cycles → scoreboard matches; `ram_addr_a` ≠ `ram_addr_b` whenever both are active; `ram_we_b`=0 always.
- **Reset mid-stream:** with 20 words held and a fetch in flight, pulse `rst` → all outputs return to reset values; next push 0x55 appears at RAM address 0 and is the first word out.
